// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state codes, register
// offsets relative to BASE_ADDR, and a helper that zero-extends a register
// field onto the 32-bit load-data bus.
package interrupt_arbiter_pkg;

  // Arbiter FSM states, 2-bit encoding (code 3 is unused).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Byte offsets of the four block registers.
  localparam logic [31:0] MASK_OFF = 32'd0;
  localparam logic [31:0] PEND_OFF = 32'd4;
  localparam logic [31:0] ACK_OFF  = 32'd8;
  localparam logic [31:0] EOI_OFF  = 32'd12;

  // Register fields are at most 8 bits wide; upper load-data bits read as 0.
  function automatic logic [31:0] zext_field(input logic [7:0] field);
    return {24'd0, field};
  endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Bus and interrupt handshake bundle between the core/peripherals and the
// interrupt arbiter. The arbiter uses the slave view; the core side
// (or a testbench) uses the master view. The tristate load-data net is kept
// as a separate port on the arbiter because it is shared with other devices.
interface interrupt_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] int_src;     // level interrupt lines from peripherals
  logic [31:0]        data;        // store data from core
  logic [31:0]        address;     // byte address from core
  logic               mem_read;    // load strobe
  logic               mem_write;   // store strobe
  logic               ic_address;  // address hits one of the block registers
  logic               int_req;     // interrupt request to core
  logic [2:0]         int_vector;  // source index of the current request
  logic               int_taken;   // core accepts the request (1-cycle pulse)
  logic [NUM_SRC-1:0] src_ack;     // per-source acknowledge, same cycle as ACK write

  modport slave (
    input  int_src, data, address, mem_read, mem_write, int_taken,
    output ic_address, int_req, int_vector, src_ack
  );

  modport master (
    output int_src, data, address, mem_read, mem_write, int_taken,
    input  ic_address, int_req, int_vector, src_ack
  );
endinterface

// File: rtl/interrupt_arbiter_rr_picker.sv
// Combinational round-robin picker. Returns the first eligible source index
// found when searching upward from rr_last+1, wrapping modulo NUM_SRC.
// Implemented as two priority searches: first among sources above rr_last,
// then, if none of those is eligible, among all sources from index 0.
module interrupt_arbiter_rr_picker #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_eligible,
  input  logic [2:0]         i_rr_last,
  output logic               o_any,
  output logic [2:0]         o_index
);
  logic [NUM_SRC-1:0]      w_above;
  logic [NUM_SRC-1:0]      w_upper;
  logic [NUM_SRC-1:0]      w_cand;
  logic [NUM_SRC-1:0]      w_onehot;
  logic [2:0][NUM_SRC-1:0] w_bit_hits;

  assign w_upper = i_eligible & w_above;
  assign w_cand  = (|w_upper) ? w_upper : i_eligible;
  assign o_any   = |i_eligible;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    // Bits strictly below gi, used to find the lowest set candidate.
    localparam logic [NUM_SRC-1:0] LOW_MASK = NUM_SRC'((1 << gi) - 1);

    assign w_above[gi]  = (3'(gi) > i_rr_last);
    assign w_onehot[gi] = w_cand[gi] & ~(|(w_cand & LOW_MASK));

    // Encode the one-hot winner: bit bi of the index is set by every source
    // whose own index has bit bi set.
    for (genvar bi = 0; bi < 3; bi++) begin : g_bit
      localparam logic IDX_BIT = (((gi >> bi) & 1) == 1);
      assign w_bit_hits[bi][gi] = w_onehot[gi] & IDX_BIT;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_index
    assign o_index[gi] = |w_bit_hits[gi];
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Memory-mapped interrupt controller. Latches level interrupt lines into
// pending bits, masks them, picks one source round-robin and offers it to the
// core with a req/taken handshake. Further requests are held off until the
// handler writes EOI. Registers: MASK (RW), PEND (RO), ACK (W1C), EOI (W).
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
  input  logic                clk,
  input  logic                rst,
  interrupt_arbiter_if.slave  bus,
  output wire  [31:0]         o_rdata
);
  // Address decode and bus-side strobes
  logic               w_sel_mask;
  logic               w_sel_pend;
  logic               w_sel_ack;
  logic               w_sel_eoi;
  logic               w_ic_read;
  logic               w_eoi;
  logic [NUM_SRC-1:0] w_clr;
  logic [31:0]        w_rdval;

  // Register state
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  state_e             r_state;
  logic               r_int_req;
  logic [2:0]         r_int_vector;
  logic [2:0]         r_rr_last;

  // Arbitration
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_granted_hits;
  logic               w_granted;
  logic               w_any;
  logic [2:0]         w_pick;

  assign w_sel_mask = (bus.address == BASE_ADDR + MASK_OFF);
  assign w_sel_pend = (bus.address == BASE_ADDR + PEND_OFF);
  assign w_sel_ack  = (bus.address == BASE_ADDR + ACK_OFF);
  assign w_sel_eoi  = (bus.address == BASE_ADDR + EOI_OFF);

  assign bus.ic_address = w_sel_mask | w_sel_pend | w_sel_ack | w_sel_eoi;

  // Only MASK and PEND are readable; ACK/EOI leave the shared bus floating.
  assign w_ic_read = bus.mem_read & (w_sel_mask | w_sel_pend);
  assign w_rdval   = w_sel_mask ? zext_field(8'(r_mask)) : zext_field(8'(r_pending));
  assign o_rdata   = w_ic_read ? w_rdval : 'z;

  // Write-one-to-clear acknowledge; also told to the sources combinationally
  // so they drop their lines on the same edge that clears the pending bit.
  assign w_clr       = (bus.mem_write & w_sel_ack) ? bus.data[NUM_SRC-1:0] : '0;
  assign bus.src_ack = w_clr;
  assign w_eoi       = bus.mem_write & w_sel_eoi;

  assign w_eligible = r_pending & r_mask;

  // The request is withdrawn when the granted source stops being eligible.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_grant
    assign w_granted_hits[gi] = w_eligible[gi] & (r_int_vector == 3'(gi));
  end
  assign w_granted = |w_granted_hits;

  interrupt_arbiter_rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_rr_last  (r_rr_last),
    .o_any      (w_any),
    .o_index    (w_pick)
  );

  assign bus.int_req    = r_int_req;
  assign bus.int_vector = r_int_vector;

  // Mask register: software-written per-source enables, 1 = enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (bus.mem_write && w_sel_mask) begin
      r_mask <= bus.data[NUM_SRC-1:0];
    end
  end

  // Pending bits: latch any high line; an ACK clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | bus.int_src) & ~w_clr;
    end
  end

  // Arbiter FSM: pick in IDLE, offer in REQ, hold off in SERVICE until EOI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_int_req    <= 1'b0;
      r_int_vector <= 3'd0;
      r_rr_last    <= 3'(NUM_SRC - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_REQ;
            r_int_req    <= 1'b1;
            r_int_vector <= w_pick;
            r_rr_last    <= w_pick;
          end
        end
        ST_REQ: begin
          if (bus.int_taken) begin
            r_state   <= ST_SERVICE;
            r_int_req <= 1'b0;
          end else if (!w_granted) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (w_eoi) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
